// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants: source encodings and tag/data widths used by the RS, LSB and ROB.
package cdb_arbiter_pkg;
  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;
  localparam int   ROB_POS_W   = 4;
  localparam int   DATA_W      = 32;
  localparam int   NUM_SRC     = 2;
endpackage

// File: rtl/result_fifo.sv
// Synchronous result FIFO with flush; a push to a full FIFO is accepted only alongside a pop.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining the ALU and LSB result FIFOs onto the single CDB, one entry per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ROB_POS_W  = cdb_arbiter_pkg::ROB_POS_W,
  parameter int DATA_W     = cdb_arbiter_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 jump_wrong,
  input  logic                 alu_valid,
  input  logic [ROB_POS_W-1:0] alu_ROB_pos,
  input  logic [DATA_W-1:0]    alu_val,
  output logic                 alu_stall,
  input  logic                 lsb_valid,
  input  logic [ROB_POS_W-1:0] lsb_ROB_pos,
  input  logic [DATA_W-1:0]    lsb_val,
  output logic                 lsb_stall,
  output logic                 cdb_valid,
  output logic [ROB_POS_W-1:0] cdb_ROB_pos,
  output logic [DATA_W-1:0]    cdb_val,
  output logic                 cdb_src,
  output logic                 overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ROB_POS_W + DATA_W;

  // Index 0 is the ALU source, index 1 the LSB source, matching the CDB_SRC encodings.
  logic [NUM_SRC-1:0]         push_req, pop, full, has;
  logic [NUM_SRC-1:0][EW-1:0] din, head;
  logic [NUM_SRC-1:0][CW-1:0] count;
  logic                       last_grant, granted, grant_src;
  logic [EW-1:0]              head_sel;

  assign push_req = {lsb_valid, alu_valid} & {NUM_SRC{rdy && !jump_wrong}};
  assign din      = {{lsb_ROB_pos, lsb_val}, {alu_ROB_pos, alu_val}};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    result_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (jump_wrong),
      .push  (push_req[i]),
      .pop   (pop[i]),
      .din   (din[i]),
      .head  (head[i]),
      .count (count[i]),
      .full  (full[i])
    );
    assign has[i] = (count[i] != '0);
    assign pop[i] = cdb_valid && (grant_src == 1'(i));
  end

  always_comb begin
    granted   = |has;
    grant_src = CDB_SRC_ALU;
    case (has)
      2'b01:   grant_src = CDB_SRC_ALU;
      2'b10:   grant_src = CDB_SRC_LSB;
      2'b11:   grant_src = ~last_grant;
      default: grant_src = CDB_SRC_ALU;
    endcase
  end

  assign head_sel    = head[grant_src];
  assign cdb_valid   = granted && rdy && !jump_wrong;
  assign cdb_ROB_pos = cdb_valid ? head_sel[EW-1:DATA_W] : '0;
  assign cdb_val     = cdb_valid ? head_sel[DATA_W-1:0]  : '0;
  assign cdb_src     = cdb_valid ? grant_src : CDB_SRC_ALU;

  // One entry of slack absorbs the producer's one-cycle reaction to stall.
  assign alu_stall = (count[CDB_SRC_ALU] >= CW'(FIFO_DEPTH - 1));
  assign lsb_stall = (count[CDB_SRC_LSB] >= CW'(FIFO_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= CDB_SRC_LSB;
      overflow   <= 1'b0;
    end else begin
      if (cdb_valid) last_grant <= grant_src;
      if (|(push_req & full & ~pop)) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: latency, round-robin, stalls, overflow, flush and rdy freeze.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong;
  logic        alu_valid, lsb_valid;
  logic [3:0]  alu_ROB_pos, lsb_ROB_pos, cdb_ROB_pos;
  logic [31:0] alu_val, lsb_val, cdb_val;
  logic        alu_stall, lsb_stall, cdb_valid, cdb_src, overflow;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.FIFO_DEPTH(4), .ROB_POS_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .alu_valid(alu_valid), .alu_ROB_pos(alu_ROB_pos), .alu_val(alu_val), .alu_stall(alu_stall),
    .lsb_valid(lsb_valid), .lsb_ROB_pos(lsb_ROB_pos), .lsb_val(lsb_val), .lsb_stall(lsb_stall),
    .cdb_valid(cdb_valid), .cdb_ROB_pos(cdb_ROB_pos), .cdb_val(cdb_val), .cdb_src(cdb_src),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_cdb(input string tag, input logic v, input logic [3:0] p,
                         input logic [31:0] d, input logic s);
    chk({tag, "_v"},   cdb_valid,   v);
    chk({tag, "_pos"}, cdb_ROB_pos, p);
    chk({tag, "_val"}, cdb_val,     d);
    chk({tag, "_src"}, cdb_src,     s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rdy = 1'b1; jump_wrong = 1'b0;
    alu_valid = 1'b0; alu_ROB_pos = '0; alu_val = '0;
    lsb_valid = 1'b0; lsb_ROB_pos = '0; lsb_val = '0;
  endtask

  task automatic drv_alu(input logic [3:0] p, input logic [31:0] v);
    alu_valid = 1'b1; alu_ROB_pos = p; alu_val = v;
  endtask

  task automatic drv_lsb(input logic [3:0] p, input logic [31:0] v);
    lsb_valid = 1'b1; lsb_ROB_pos = p; lsb_val = v;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [35:0] qa[$];
    logic [35:0] ql[$];
    logic [35:0] e;
    logic        ea, el, s, stall_seen;
    int ov_pos[14] = '{-1, 0, 8, 1, 9, 2, 10, 3, 11, 4, 5, 6, 7, -1};

    // Reset state
    do_reset();
    #1;
    chk_cdb("rst", 1'b0, 4'd0, 32'd0, 1'b0);
    chk("rst_astall", alu_stall, 1'b0);
    chk("rst_lstall", lsb_stall, 1'b0);
    chk("rst_ovf",    overflow,  1'b0);

    // Single ALU result: one-cycle latency, then idle
    drv_alu(4'd3, 32'h11);
    #1; chk("single_c0_v", cdb_valid, 1'b0);
    tick(); idle(); #1;
    chk_cdb("single_c1", 1'b1, 4'd3, 32'h11, CDB_SRC_ALU);
    tick(); #1;
    chk("single_c2_v", cdb_valid, 1'b0);

    // Simultaneous results after reset: ALU wins the first tie
    do_reset();
    drv_alu(4'd2, 32'hA); drv_lsb(4'd5, 32'hB);
    tick(); idle(); #1;
    chk_cdb("simul_c1", 1'b1, 4'd2, 32'hA, CDB_SRC_ALU);
    tick(); #1;
    chk_cdb("simul_c2", 1'b1, 4'd5, 32'hB, CDB_SRC_LSB);
    tick(); #1;
    chk("simul_c3_v", cdb_valid, 1'b0);

    // Sustained contention, producers obey stall
    do_reset();
    stall_seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      idle();
      ea = (qa.size() >= 3);
      el = (ql.size() >= 3);
      if (!ea) drv_alu(4'(c), 32'hA000_0000 + 32'(c));
      if (!el) drv_lsb(4'(c + 8), 32'hB000_0000 + 32'(c));
      #1;
      chk("sus_astall", alu_stall, ea);
      chk("sus_lstall", lsb_stall, el);
      if (ea || el) stall_seen = 1'b1;
      if (c == 0) chk_cdb("sus_c0", 1'b0, 4'd0, 32'd0, 1'b0);
      else begin
        s = (c % 2 == 1) ? CDB_SRC_ALU : CDB_SRC_LSB;
        e = (s == CDB_SRC_ALU) ? qa.pop_front() : ql.pop_front();
        chk_cdb("sus", 1'b1, e[35:32], e[31:0], s);
      end
      if (!ea) qa.push_back({4'(c), 32'hA000_0000 + 32'(c)});
      if (!el) ql.push_back({4'(c + 8), 32'hB000_0000 + 32'(c)});
      tick();
    end
    idle(); #1;
    chk("sus_stall_seen", stall_seen, 1'b1);
    chk("sus_ovf", overflow, 1'b0);

    // Overflow: ALU fills while LSB backlog takes alternate grants
    do_reset();
    for (int c = 0; c < 14; c++) begin
      idle();
      if (c <= 8) drv_alu(4'(c), 32'hA0 + 32'(c));
      if (c <= 3) drv_lsb(4'(c + 8), 32'hB8 + 32'(c));
      #1;
      if (ov_pos[c] < 0) chk_cdb("ovf_none", 1'b0, 4'd0, 32'd0, 1'b0);
      else if (ov_pos[c] >= 8)
        chk_cdb("ovf_lsb", 1'b1, 4'(ov_pos[c]), 32'hB0 + 32'(ov_pos[c]), CDB_SRC_LSB);
      else
        chk_cdb("ovf_alu", 1'b1, 4'(ov_pos[c]), 32'hA0 + 32'(ov_pos[c]), CDB_SRC_ALU);
      if (c == 3) chk("ovf_c3_astall", alu_stall, 1'b0);
      if (c == 6) chk("ovf_c6_astall", alu_stall, 1'b1);
      if (c == 8) chk("ovf_c8_flag", overflow, 1'b0);
      if (c == 9) chk("ovf_c9_flag", overflow, 1'b1);
      tick();
    end
    idle(); jump_wrong = 1'b1; #1;
    chk("ovf_jw_v", cdb_valid, 1'b0);
    tick(); idle(); #1;
    chk("ovf_after_jw", overflow, 1'b1);

    // Flush: 3 ALU entries queued, concurrent LSB push dropped
    do_reset();
    for (int c = 0; c < 5; c++) begin
      idle();
      drv_alu(4'(c + 1), 32'h50 + 32'(c));
      if (c == 0 || c == 1 || c == 3) drv_lsb(4'(c + 8), 32'h60 + 32'(c));
      tick();
    end
    idle(); jump_wrong = 1'b1; drv_lsb(4'd14, 32'hEE); #1;
    chk("flush_c5_astall", alu_stall, 1'b1);
    chk("flush_c5_v", cdb_valid, 1'b0);
    tick(); idle(); #1;
    chk("flush_c6_v", cdb_valid, 1'b0);
    chk("flush_c6_astall", alu_stall, 1'b0);
    chk("flush_c6_lstall", lsb_stall, 1'b0);
    drv_alu(4'd9, 32'h99);
    tick(); idle(); #1;
    chk_cdb("flush_c7", 1'b1, 4'd9, 32'h99, CDB_SRC_ALU);
    tick(); #1;
    chk("flush_c8_v", cdb_valid, 1'b0);

    // rdy freeze with two queued entries
    do_reset();
    drv_alu(4'd6, 32'h66); drv_lsb(4'd7, 32'h77);
    tick();
    for (int c = 0; c < 3; c++) begin
      idle(); rdy = 1'b0; drv_alu(4'd15, 32'hDEAD); #1;
      chk_cdb("frz", 1'b0, 4'd0, 32'd0, 1'b0);
      tick();
    end
    idle(); #1;
    chk_cdb("frz_d0", 1'b1, 4'd6, 32'h66, CDB_SRC_ALU);
    tick(); #1;
    chk_cdb("frz_d1", 1'b1, 4'd7, 32'h77, CDB_SRC_LSB);
    tick(); #1;
    chk("frz_d2_v", cdb_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) between the two result producers of the out-of-order core: the ALU result from the reservation station and the load result from the load/store buffer. Each producer has a small result FIFO. A round-robin scheduler drains one entry per cycle onto the CDB, which the reservation station, load/store buffer and ROB consume. The block throttles producers with stall signals and drops all in-flight results on a branch mispredict flush.

## Interface
- `FIFO_DEPTH`, 4: entries per producer FIFO; power of two, ≥ 2.
- `ROB_POS_W`, 4: ROB index width.
- `DATA_W`, 32: result width.

- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `rdy`  in  1  global enable; low = freeze all state
- `jump_wrong`  in  1  mispredict flush
- `alu_valid`  in  1  ALU result present this cycle
- `alu_ROB_pos`  in  ROB_POS_W  ALU result tag
- `alu_val`  in  DATA_W  ALU result value
- `alu_stall`  out  1  ALU FIFO has ≤ 1 free entry; RS must not issue
- `lsb_valid`  in  1  load result present this cycle
- `lsb_ROB_pos`  in  ROB_POS_W  load result tag
- `lsb_val`  in  DATA_W  load result value
- `lsb_stall`  out  1  LSB FIFO has ≤ 1 free entry
- `cdb_valid`  out  1  broadcast valid
- `cdb_ROB_pos`  out  ROB_POS_W  broadcast tag
- `cdb_val`  out  DATA_W  broadcast value
- `cdb_src`  out  1  granted source (`CDB_SRC_ALU`/`CDB_SRC_LSB`)
- `overflow`  out  1  sticky: a push was dropped because the FIFO was full

## Operation
- Two independent FIFOs (ALU, LSB), each holding {ROB_pos, val}. A push occurs when `*_valid && rdy && !jump_wrong && !rst`.
- Grant is combinational from FIFO occupancy at the start of the cycle:
  - Neither FIFO has an entry: no grant.
  - Only one FIFO has an entry: grant it.
  - Both have entries: grant the source opposite to `last_grant`.
- `cdb_valid = granted && rdy && !jump_wrong`. `cdb_ROB_pos`, `cdb_val` and `cdb_src` come from the granted FIFO's head; they are 0 when `cdb_valid` is 0.
- Pop of the granted head happens at the clock edge when `cdb_valid` is 1. `last_grant` updates to `cdb_src` on each pop.
- Push and pop on the same FIFO in the same cycle are allowed, including when full (count unchanged).
- Push to a full FIFO with no pop: the input is dropped and `overflow` is set to 1. `overflow` clears only on `rst`.
- There is no bypass path. An entry pushed in cycle n is eligible no earlier than cycle n+1.
- `*_stall = (count ≥ FIFO_DEPTH-1)`, decoded from registered count. One entry of slack covers the producer's one-cycle reaction time.
- `jump_wrong` at an edge empties both FIFOs and drops same-cycle pushes. `last_grant` is kept. `overflow` is kept.
- Priority at an edge: `rst` > `jump_wrong` > `!rdy` (hold) > normal operation.

## Timing
- Reset values:
  - `cdb_valid`=0, `cdb_ROB_pos`=0, `cdb_val`=0, `cdb_src`=0
  - `alu_stall`=0, `lsb_stall`=0, `overflow`=0
  - both counts 0; `last_grant`=`CDB_SRC_LSB`, so the ALU wins the first tie.
- Latency: input valid in cycle n, uncontended → `cdb_valid` in cycle n+1.
- Throughput: 1 broadcast per cycle. Under sustained contention the sources alternate strictly.
- No combinational path from any `*_valid`/`*_val` input to any output. Outputs depend only on FIFO state, `last_grant`, `rdy` and `jump_wrong`.
- Pointers wrap modulo FIFO_DEPTH. Count is tracked with log2(FIFO_DEPTH)+1 bits.
- `rst` asserted mid-operation: all contents are discarded at that edge; there is no partial drain.

## Structure
- `defines.v` gains the following:
  - `CDB_SRC_ALU` = 1'b0
  - `CDB_SRC_LSB` = 1'b1
  - shared `ROB_POS_W` / `DATA_W` constants for the RS, LSB and ROB.
- One sub-module, `result_fifo`: a parameterised synchronous FIFO with push, pop, flush, head, count and full. It is instantiated twice. Arbitration, stall decode and the overflow flag live in `cdb_arbiter`.

## Test plan
- Single ALU result: push {ROB 3, 0x11} in cycle 0 → cdb {1, ROB 3, 0x11, ALU} in cycle 1; `cdb_valid`=0 in cycle 2.
- Simultaneous results: ALU {2, 0xA} and LSB {5, 0xB} pushed in cycle 0 after reset → cycle 1 broadcasts ALU 2, cycle 2 broadcasts LSB 5.
- Sustained contention: both sources push every cycle while obeying stall → broadcasts alternate ALU/LSB every cycle; stalls assert once count reaches 3; no `overflow`.
- Overflow: hold `rdy`=1, fill the ALU FIFO to 4 while an LSB backlog wins alternate grants, then push a fifth ALU result with no ALU pop → entry dropped, `overflow`=1 and stays 1 through `jump_wrong`.
- Flush: 3 ALU entries queued, `jump_wrong` for 1 cycle with a concurrent LSB push → `cdb_valid`=0 in the flush cycle and the next; counts 0; stalls 0.
- rdy freeze: 2 entries queued, `rdy`=0 for 3 cycles → `cdb_valid`=0 and no pops; on `rdy`=1 the entries drain in their original order on consecutive cycles.
